// File: rtl/jtframe_ps2_rx.sv
// PS/2 device-to-host receiver: deglitches clock/data, deserialises 11-bit frames
// and folds E0/F0 prefixes into extended/released flags on each key event.
module jtframe_ps2_rx #(
   parameter int unsigned FILTER  = 8,
   parameter int unsigned TOUTW   = 17,
   parameter int unsigned TIMEOUT = 96000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] raw_data,
   output logic       raw_valid,
   output logic [7:0] key_code,
   output logic       key_extended,
   output logic       key_released,
   output logic       key_valid,
   output logic       parity_err,
   output logic       frame_err
);

   localparam logic [7:0]       FILT_LAST = 8'(FILTER - 1);
   localparam logic [TOUTW-1:0] TMO_LAST  = TOUTW'(TIMEOUT - 1);
   localparam logic [7:0]       CODE_EXT  = 8'hE0;
   localparam logic [7:0]       CODE_REL  = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic       clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
   logic [7:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
   logic       clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
   logic       clk_filt_dly_q;
   logic       fall_q, fall_d;
   logic       dat_smp_q;

   always_comb begin
      clk_cnt_d  = '0;
      clk_filt_d = clk_filt_q;
      dat_cnt_d  = '0;
      dat_filt_d = dat_filt_q;
      // Any sample that agrees with the filtered level restarts the run.
      if (clk_sync_q != clk_filt_q) begin
         if (clk_cnt_q == FILT_LAST) clk_filt_d = clk_sync_q;
         else                        clk_cnt_d  = clk_cnt_q + 8'd1;
      end
      if (dat_sync_q != dat_filt_q) begin
         if (dat_cnt_q == FILT_LAST) dat_filt_d = dat_sync_q;
         else                        dat_cnt_d  = dat_cnt_q + 8'd1;
      end
      fall_d = clk_filt_dly_q & ~clk_filt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: both lines idle high, so the synchroniser and filter reset to 1;
         // resetting them to 0 would fake a rising edge right after reset.
         clk_meta_q     <= 1'b1;
         clk_sync_q     <= 1'b1;
         dat_meta_q     <= 1'b1;
         dat_sync_q     <= 1'b1;
         clk_cnt_q      <= '0;
         dat_cnt_q      <= '0;
         clk_filt_q     <= 1'b1;
         dat_filt_q     <= 1'b1;
         clk_filt_dly_q <= 1'b1;
         fall_q         <= 1'b0;
         dat_smp_q      <= 1'b1;
      end else begin
         clk_meta_q     <= ps2_clk;
         clk_sync_q     <= clk_meta_q;
         dat_meta_q     <= ps2_data;
         dat_sync_q     <= dat_meta_q;
         clk_cnt_q      <= clk_cnt_d;
         dat_cnt_q      <= dat_cnt_d;
         clk_filt_q     <= clk_filt_d;
         dat_filt_q     <= dat_filt_d;
         clk_filt_dly_q <= clk_filt_q;
         fall_q         <= fall_d;
         dat_smp_q      <= dat_filt_q;
      end
   end

   // ------------------------------------------------------------------
   // Frame state machine, prefix decode and timeout
   // ------------------------------------------------------------------
   state_t           state_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       shift_q;
   logic             par_q;
   logic [TOUTW-1:0] timer_q;
   logic             ext_pend_q, rel_pend_q;
   logic [7:0]       raw_data_q, key_code_q;
   logic             raw_valid_q, key_valid_q, key_extended_q, key_released_q;
   logic             parity_err_q, frame_err_q;
   logic             par_ok;

   assign par_ok = ^{shift_q, par_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         par_q          <= 1'b0;
         timer_q        <= '0;
         ext_pend_q     <= 1'b0;
         rel_pend_q     <= 1'b0;
         raw_data_q     <= '0;
         key_code_q     <= '0;
         raw_valid_q    <= 1'b0;
         key_valid_q    <= 1'b0;
         key_extended_q <= 1'b0;
         key_released_q <= 1'b0;
         parity_err_q   <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low every cycle; the branches below only
         // raise them, which guarantees one-cycle pulses without extra clears.
         raw_valid_q  <= 1'b0;
         key_valid_q  <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               timer_q <= '0;
               if (fall_q && !dat_smp_q) begin
                  state_q   <= ST_DATA;
                  bit_cnt_q <= '0;
               end
            end
            default: begin
               if (fall_q) begin
                  timer_q <= '0;
                  case (state_q)
                     ST_DATA: begin
                        shift_q   <= {dat_smp_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                     end
                     ST_PARITY: begin
                        par_q   <= dat_smp_q;
                        state_q <= ST_STOP;
                     end
                     default: begin
                        state_q <= ST_IDLE;
                        if (!dat_smp_q) begin
                           frame_err_q <= 1'b1;
                           ext_pend_q  <= 1'b0;
                           rel_pend_q  <= 1'b0;
                        end else if (!par_ok) begin
                           parity_err_q <= 1'b1;
                           ext_pend_q   <= 1'b0;
                           rel_pend_q   <= 1'b0;
                        end else begin
                           raw_valid_q <= 1'b1;
                           raw_data_q  <= shift_q;
                           if (shift_q == CODE_EXT) begin
                              ext_pend_q <= 1'b1;
                           end else if (shift_q == CODE_REL) begin
                              rel_pend_q <= 1'b1;
                           end else begin
                              key_valid_q    <= 1'b1;
                              key_code_q     <= shift_q;
                              key_extended_q <= ext_pend_q;
                              key_released_q <= rel_pend_q;
                              ext_pend_q     <= 1'b0;
                              rel_pend_q     <= 1'b0;
                           end
                        end
                     end
                  endcase
               end else if (timer_q == TMO_LAST) begin
                  // Counting from 0 after the last edge, this fires TIMEOUT cycles later.
                  state_q     <= ST_IDLE;
                  timer_q     <= '0;
                  frame_err_q <= 1'b1;
                  ext_pend_q  <= 1'b0;
                  rel_pend_q  <= 1'b0;
               end else if (timer_q != '1) begin
                  timer_q <= timer_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign raw_data     = raw_data_q;
   assign raw_valid    = raw_valid_q;
   assign key_code     = key_code_q;
   assign key_extended = key_extended_q;
   assign key_released = key_released_q;
   assign key_valid    = key_valid_q;
   assign parity_err   = parity_err_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_jtframe_ps2_rx.sv
// Bench for jtframe_ps2_rx: directed frames plus random prefix/error mixes,
// scored against a frame-level model of the receiver's observable behaviour.
module tb_jtframe_ps2_rx;

   localparam int FILTER  = 8;
   localparam int TOUTW   = 12;
   localparam int TIMEOUT = 400;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] raw_data, key_code;
   logic       raw_valid, key_extended, key_released, key_valid, parity_err, frame_err;

   jtframe_ps2_rx #(
      .FILTER  (FILTER),
      .TOUTW   (TOUTW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .raw_data     (raw_data),
      .raw_valid    (raw_valid),
      .key_code     (key_code),
      .key_extended (key_extended),
      .key_released (key_released),
      .key_valid    (key_valid),
      .parity_err   (parity_err),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: counts high cycles of each pulse output, so a stuck pulse shows up.
   int n_raw = 0, n_key = 0, n_perr = 0, n_ferr = 0, n_kv_alone = 0, last_ferr_cyc = -1;
   always @(negedge clk) begin
      if (raw_valid)              n_raw         <= n_raw + 1;
      if (key_valid)              n_key         <= n_key + 1;
      if (key_valid && !raw_valid) n_kv_alone   <= n_kv_alone + 1;
      if (parity_err)             n_perr        <= n_perr + 1;
      if (frame_err) begin
         n_ferr        <= n_ferr + 1;
         last_ferr_cyc <= cyc;
      end
   end

   // Reference model state
   int         e_raw = 0, e_key = 0, e_perr = 0, e_ferr = 0;
   bit         m_ext = 1'b0, m_rel = 1'b0;
   logic [7:0] e_raw_last = 8'h00;
   logic [9:0] e_key_last = 10'h000;

   int n_cmp = 0, n_mis = 0;
   int last_fall_cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      if (bad_stop) begin
         e_ferr++;
         m_ext = 1'b0;
         m_rel = 1'b0;
      end else if (bad_par) begin
         e_perr++;
         m_ext = 1'b0;
         m_rel = 1'b0;
      end else begin
         e_raw++;
         e_raw_last = b;
         if (b == 8'hE0)      m_ext = 1'b1;
         else if (b == 8'hF0) m_rel = 1'b1;
         else begin
            e_key++;
            e_key_last = {m_rel, m_ext, b};
            m_ext = 1'b0;
            m_rel = 1'b0;
         end
      end
   endtask

   // Device-side serialiser: data changes while the clock is high, 40-cycle bit period.
   task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit glitch);
      logic [10:0] fr;
      fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         tick(10);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         tick(20);
         ps2_clk = 1'b1;
         if (glitch) begin
            tick(5);
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(2);
         end else begin
            tick(10);
         end
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit glitch);
      send_bits(b, bad_par, bad_stop, 11, glitch);
      tick(30);
      model_frame(b, bad_par, bad_stop);
   endtask

   task automatic check_state(input string tag);
      check($sformatf("%s.raw_cnt", tag),  n_raw,  e_raw);
      check($sformatf("%s.key_cnt", tag),  n_key,  e_key);
      check($sformatf("%s.perr_cnt", tag), n_perr, e_perr);
      check($sformatf("%s.ferr_cnt", tag), n_ferr, e_ferr);
      check($sformatf("%s.raw_data", tag), raw_data, e_raw_last);
      check($sformatf("%s.key", tag), {key_released, key_extended, key_code}, e_key_last);
      check($sformatf("%s.kv_alone", tag), n_kv_alone, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int         r, budget;
      bit         bp, bs;

      // Reset state
      tick(5);
      check("reset.outputs", {raw_data, key_code, raw_valid, key_extended, key_released,
                              key_valid, parity_err, frame_err}, 0);
      rst_n = 1'b1;
      tick(20);
      check_state("idle");

      // Plain make code
      send_frame(8'h1C, 0, 0, 0);
      check_state("make_1c");

      // Extended break sequence, then a plain code clears the flags
      send_frame(8'hE0, 0, 0, 0);
      check_state("pre_e0");
      send_frame(8'hF0, 0, 0, 0);
      check_state("pre_f0");
      send_frame(8'h75, 0, 0, 0);
      check_state("ext_rel_75");
      send_frame(8'h1C, 0, 0, 0);
      check_state("after_75");

      // Bad parity on a prefix drops the pending release flag
      send_frame(8'hF0, 1, 0, 0);
      check_state("par_err_f0");
      send_frame(8'h1C, 0, 0, 0);
      check_state("after_par_err");

      // Bad stop bit
      send_frame(8'h1C, 0, 1, 0);
      check_state("stop_err");

      // Truncated frame aborted by the inactivity timer
      send_frame(8'hE0, 0, 0, 0);
      send_bits(8'h5A, 0, 0, 5, 0);
      budget = 0;
      while (n_ferr == e_ferr && budget < TIMEOUT + 100) begin
         tick(1);
         budget++;
      end
      tick(5);
      model_frame(8'h00, 0, 1);
      check("timeout.cycle", last_ferr_cyc, last_fall_cyc + FILTER + TIMEOUT + 4);
      check_state("timeout");
      send_frame(8'h29, 0, 0, 0);
      check_state("after_timeout_29");

      // Short clock glitches inside every bit
      send_frame(8'h1C, 0, 0, 1);
      check_state("glitch_1c");

      // Reset mid-frame
      send_frame(8'hE0, 0, 0, 0);
      send_bits(8'h33, 0, 0, 6, 0);
      rst_n = 1'b0;
      tick(2);
      check("midreset.outputs", {raw_data, key_code, raw_valid, key_extended, key_released,
                                 key_valid, parity_err, frame_err}, 0);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(3);
      rst_n = 1'b1;
      m_ext = 1'b0;
      m_rel = 1'b0;
      e_raw_last = 8'h00;
      e_key_last = 10'h000;
      tick(20);
      check_state("midreset_idle");
      send_frame(8'h1C, 0, 0, 0);
      check_state("after_reset_1c");

      // Random mix of prefixes, codes and corrupted frames
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 99);
         if (r < 20)      b = 8'hE0;
         else if (r < 40) b = 8'hF0;
         else             b = 8'($urandom_range(0, 255));
         bp = ($urandom_range(0, 99) < 8);
         bs = ($urandom_range(0, 99) < 6);
         send_frame(b, bp, bs, 0);
         check_state($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
